// File: rtl/rr_arb8_ctrl_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: widths, FSM states and
// the index-to-one-hot helper.
package rr_arb8_ctrl_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  // Encoding 2'd3 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  function automatic logic [N_REQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational rotating priority search: first set request at or after ptr,
// wrapping modulo 8.
module rr_pick8
  import rr_arb8_ctrl_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] win_idx
);

  logic [IDX_W-1:0] cand;
  logic             found;

  assign any = |req;

  always_comb begin
    win_idx = '0;
    cand    = '0;
    found   = 1'b0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      cand = ptr + IDX_W'(i);
      if (!found && req[cand]) begin
        win_idx = cand;
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arb8_ctrl.sv
// Round-robin arbiter for 8 requesters with a bounded tenure and one idle
// turnaround cycle between grants; all outputs registered.
module rr_arb8_ctrl
  import rr_arb8_ctrl_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             timeout
);

  localparam int unsigned      HC_W      = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [HC_W-1:0]  hold_q, hold_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             vld_q, vld_d;
  logic             to_q, to_d;

  logic             any_c;
  logic [IDX_W-1:0] win_c;
  logic             gnt_en_c;
  logic [IDX_W-1:0] gnt_sel_c;

  rr_pick8 u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .any     (any_c),
    .win_idx (win_c)
  );

  // Next-state: arbitrate from IDLE/GAP, hold or release/preempt from GRANT.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    idx_d     = idx_q;
    vld_d     = vld_q;
    to_d      = 1'b0;
    gnt_en_c  = 1'b0;
    gnt_sel_c = win_c;

    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (any_c) begin
          state_d   = ST_GRANT;
          idx_d     = win_c;
          vld_d     = 1'b1;
          hold_d    = '0;
          gnt_en_c  = 1'b1;
          gnt_sel_c = win_c;
        end else begin
          state_d = ST_IDLE;
          vld_d   = 1'b0;
        end
      end
      ST_GRANT: begin
        if (!req[idx_q] || (hold_q == HOLD_LAST)) begin
          state_d = ST_GAP;
          vld_d   = 1'b0;
          ptr_d   = idx_q + IDX_W'(1);
          to_d    = req[idx_q];
        end else begin
          hold_d    = hold_q + HC_W'(1);
          gnt_en_c  = 1'b1;
          gnt_sel_c = idx_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        vld_d   = 1'b0;
      end
    endcase

    gnt_d = gnt_en_c ? idx2onehot(gnt_sel_c) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      to_q    <= to_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = idx_q;
  assign gnt_vld = vld_q;
  assign timeout = to_q;

endmodule

// File: tb/tb_rr_arb8_ctrl.sv
// Bench for rr_arb8_ctrl: three instances (MAX_HOLD 16/4/1) share stimulus and
// are compared every cycle against a tenure-counting model plus literal points.
module tb_rr_arb8_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;

  logic [7:0] gnt_w [3];
  logic [2:0] idx_w [3];
  logic       vld_w [3];
  logic       to_w  [3];

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  rr_arb8_ctrl #(.MAX_HOLD(16)) u_h16 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt_w[0]), .gnt_idx(idx_w[0]), .gnt_vld(vld_w[0]), .timeout(to_w[0])
  );
  rr_arb8_ctrl #(.MAX_HOLD(4)) u_h4 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt_w[1]), .gnt_idx(idx_w[1]), .gnt_vld(vld_w[1]), .timeout(to_w[1])
  );
  rr_arb8_ctrl #(.MAX_HOLD(1)) u_h1 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt_w[2]), .gnt_idx(idx_w[2]), .gnt_vld(vld_w[2]), .timeout(to_w[2])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else
      n_pass++;
  endtask

  // Model: owner keeps the resource while requesting, for at most mh visible
  // cycles; a cycle with no grant follows every tenure; search starts after
  // the last owner.
  int unsigned mh [3] = '{16, 4, 1};
  logic [7:0]  e_gnt [3];
  logic [2:0]  e_idx [3];
  logic        e_vld [3];
  logic        e_to  [3];
  int          e_ptr [3];
  int          e_ten [3];

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        e_gnt[k] = 8'h00; e_idx[k] = 3'd0; e_vld[k] = 1'b0;
        e_to[k]  = 1'b0;  e_ptr[k] = 0;    e_ten[k] = 0;
      end else if (e_vld[k]) begin
        if (!req[e_idx[k]] || e_ten[k] == int'(mh[k])) begin
          e_to[k]  = req[e_idx[k]];
          e_vld[k] = 1'b0;
          e_gnt[k] = 8'h00;
          e_ptr[k] = (int'(e_idx[k]) + 1) % 8;
        end else begin
          e_ten[k] = e_ten[k] + 1;
        end
      end else begin
        e_to[k] = 1'b0;
        for (int j = 0; j < 8; j++) begin
          int c;
          c = (e_ptr[k] + j) % 8;
          if (!e_vld[k] && req[c]) begin
            e_vld[k] = 1'b1;
            e_idx[k] = 3'(c);
            e_gnt[k] = 8'(1) << c;
            e_ten[k] = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("model_gnt[%0d]", k), 32'(gnt_w[k]), 32'(e_gnt[k]));
        chk($sformatf("model_idx[%0d]", k), 32'(idx_w[k]), 32'(e_idx[k]));
        chk($sformatf("model_vld[%0d]", k), 32'(vld_w[k]), 32'(e_vld[k]));
        chk($sformatf("model_to[%0d]",  k), 32'(to_w[k]),  32'(e_to[k]));
      end
    end
  end

  task automatic idle_cycles(input int n);
    req = 8'h00;
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int seq[$];
    int run;
    int gap;
    bit prev_v;

    // Reset held with every requester active.
    req   = 8'hFF;
    rst_n = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_gnt[%0d]", k), 32'(gnt_w[k]), 32'h0);
      chk($sformatf("rst_vld[%0d]", k), 32'(vld_w[k]), 32'h0);
      chk($sformatf("rst_to[%0d]",  k), 32'(to_w[k]),  32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_gnt", 32'(gnt_w[0]), 32'h01);
    chk("first_idx", 32'(idx_w[0]), 32'h0);

    // Rotation: each owner of the 16-hold instance drops after 2 cycles.
    run = 0; gap = 0; prev_v = 1'b0;
    for (int it = 0; it < 28; it++) begin
      if (vld_w[0]) begin
        if (!prev_v) begin
          if (seq.size() > 0) chk("rot_gap", 32'(gap), 32'd1);
          seq.push_back(int'(idx_w[0]));
          run = 1;
        end else begin
          run++;
        end
        gap = 0;
      end else begin
        if (prev_v) chk("rot_tenure", 32'(run), 32'd2);
        gap++;
      end
      prev_v = vld_w[0];
      req = 8'hFF;
      if (vld_w[0] && run == 2) req[idx_w[0]] = 1'b0;
      @(negedge clk);
    end
    chk("rot_count", 32'(seq.size() >= 9), 32'd1);
    for (int i = 0; i < 9 && i < seq.size(); i++)
      chk($sformatf("rot_seq[%0d]", i), 32'(seq[i]), 32'(i % 8));

    // Hold timer: sole requester 3.
    idle_cycles(3);
    req = 8'h08;
    @(negedge clk);
    chk("to4_c1", 32'(gnt_w[1]), 32'h08);
    chk("to1_c1", 32'(gnt_w[2]), 32'h08);
    @(negedge clk);
    chk("to4_c2", 32'(gnt_w[1]), 32'h08);
    chk("to1_gap", 32'(gnt_w[2]), 32'h00);
    chk("to1_pulse", 32'(to_w[2]), 32'h1);
    @(negedge clk);
    chk("to4_c3", 32'(gnt_w[1]), 32'h08);
    @(negedge clk);
    chk("to4_c4", 32'(gnt_w[1]), 32'h08);
    @(negedge clk);
    chk("to4_gap", 32'(gnt_w[1]), 32'h00);
    chk("to4_pulse", 32'(to_w[1]), 32'h1);
    @(negedge clk);
    chk("to4_regrant", 32'(gnt_w[1]), 32'h08);
    chk("to4_pulse_end", 32'(to_w[1]), 32'h0);

    // Wrap: release requester 6 so search starts at 7.
    idle_cycles(3);
    req = 8'h40;
    @(negedge clk);
    chk("wrap_g6", 32'(gnt_w[0]), 32'h40);
    req = 8'h00;
    @(negedge clk);
    chk("wrap_gap", 32'(gnt_w[0]), 32'h00);
    req = 8'h81;
    @(negedge clk);
    chk("wrap_g7", 32'(gnt_w[0]), 32'h80);
    req = 8'h01;
    @(negedge clk);
    chk("wrap_gap2", 32'(gnt_w[0]), 32'h00);
    @(negedge clk);
    chk("wrap_g0", 32'(gnt_w[0]), 32'h01);

    // Reset during a grant clears the pointer too.
    idle_cycles(3);
    req = 8'h20;
    @(negedge clk);
    chk("mid_g5", 32'(gnt_w[0]), 32'h20);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_gnt", 32'(gnt_w[0]), 32'h00);
    chk("mid_rst_vld", 32'(vld_w[0]), 32'h0);
    chk("mid_rst_idx", 32'(idx_w[0]), 32'h0);
    rst_n = 1'b1;
    req   = 8'h21;
    @(negedge clk);
    chk("mid_after", 32'(gnt_w[0]), 32'h01);

    // Other requesters toggling must not disturb the owner.
    idle_cycles(3);
    req = 8'h02;
    @(negedge clk);
    chk("ign_start16", 32'(gnt_w[0]), 32'h02);
    chk("ign_start4", 32'(gnt_w[1]), 32'h02);
    for (int i = 0; i < 6; i++) begin
      req = (i % 2 == 1) ? 8'h02 : 8'hFE;
      @(negedge clk);
      chk($sformatf("ign_hold[%0d]", i), 32'(gnt_w[0]), 32'h02);
      if (i == 3) begin
        chk("ign_h4_gap", 32'(gnt_w[1]), 32'h00);
        chk("ign_h4_to", 32'(to_w[1]), 32'h1);
      end
    end
    req = 8'hFC;
    @(negedge clk);
    chk("ign_release", 32'(gnt_w[0]), 32'h00);
    chk("ign_release_to", 32'(to_w[0]), 32'h0);

    idle_cycles(4);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
